// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// Module   : load_store_unit
// Purpose  : Memory-access stage for a big-endian, word-only data memory.
//            Sub-word loads are extracted and extended; SB/SH use read-modify-write.
// Revision : 1.0
// ============================================================================
module load_store_unit #(
    parameter logic [31:0] BASE_ADDR = 32'h8002_0000,
    parameter int unsigned MEM_BYTES = 32'd1048576
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_store,
    input  logic [2:0]  req_op,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [4:0]  req_rd,
    output logic [31:0] mem_address,
    output logic [31:0] mem_data_in,
    output logic [1:0]  mem_access_size,
    output logic        mem_rw,
    output logic        mem_enable,
    input  logic [31:0] mem_data_out,
    output logic        done,
    output logic        wb_valid,
    output logic [31:0] wb_data,
    output logic [4:0]  wb_rd,
    output logic        fault
);

    localparam logic [2:0]  c_op_b    = 3'b000;
    localparam logic [2:0]  c_op_h    = 3'b001;
    localparam logic [2:0]  c_op_w    = 3'b011;
    localparam logic [2:0]  c_op_bu   = 3'b100;
    localparam logic [2:0]  c_op_hu   = 3'b101;
    localparam logic [32:0] c_addr_lo = {1'b0, BASE_ADDR};
    localparam logic [32:0] c_addr_hi = {1'b0, BASE_ADDR} + 33'(MEM_BYTES);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD   = 3'd1,
        ST_CAP  = 3'd2,
        ST_WR   = 3'd3,
        ST_FIN  = 3'd4
    } state_t;

    state_t      r_state;
    logic        r_store;
    logic [2:0]  r_op;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [4:0]  r_rd;
    logic        r_fault;

    logic        w_accept;
    logic        w_fault;
    logic [31:0] w_load_data;
    logic [31:0] w_merge_data;

    function automatic logic f_is_fault(input logic st, input logic [2:0] op,
                                        input logic [31:0] a);
        logic bad;
        bad = ({1'b0, a} < c_addr_lo) || ({1'b0, a} >= c_addr_hi);
        case (op)
            c_op_b:  bad = bad;
            c_op_bu: bad = bad | st;
            c_op_h:  bad = bad | a[0];
            c_op_hu: bad = bad | st | a[0];
            c_op_w:  bad = bad | (a[1:0] != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

    function automatic logic [31:0] f_extract(input logic [2:0] op, input logic [1:0] off,
                                              input logic [31:0] word);
        logic [7:0]  lane_b;
        logic [15:0] lane_h;
        logic [31:0] res;
        case (off)
            2'd0:    lane_b = word[31:24];
            2'd1:    lane_b = word[23:16];
            2'd2:    lane_b = word[15:8];
            default: lane_b = word[7:0];
        endcase
        lane_h = off[1] ? word[15:0] : word[31:16];
        case (op)
            c_op_b:  res = {{24{lane_b[7]}}, lane_b};
            c_op_bu: res = {24'h0, lane_b};
            c_op_h:  res = {{16{lane_h[15]}}, lane_h};
            c_op_hu: res = {16'h0, lane_h};
            default: res = word;
        endcase
        return res;
    endfunction

    // Replace only the addressed lane of the word read back during CAP.
    function automatic logic [31:0] f_merge(input logic [2:0] op, input logic [1:0] off,
                                            input logic [31:0] word, input logic [31:0] wd);
        logic [31:0] res;
        res = word;
        if (op == c_op_h) begin
            if (off[1]) res[15:0]  = wd[15:0];
            else        res[31:16] = wd[15:0];
        end else begin
            case (off)
                2'd0:    res[31:24] = wd[7:0];
                2'd1:    res[23:16] = wd[7:0];
                2'd2:    res[15:8]  = wd[7:0];
                default: res[7:0]   = wd[7:0];
            endcase
        end
        return res;
    endfunction

    assign req_ready    = (r_state == ST_IDLE);
    assign w_accept     = req_valid & req_ready;
    assign w_fault      = f_is_fault(req_store, req_op, req_addr);
    assign w_load_data  = f_extract(r_op, r_addr[1:0], mem_data_out);
    assign w_merge_data = f_merge(r_op, r_addr[1:0], mem_data_out, r_wdata);

    always_comb begin
        mem_address     = {r_addr[31:2], 2'b00};
        mem_access_size = 2'b00;
        mem_enable      = (r_state == ST_RD) || (r_state == ST_WR);
        mem_rw          = (r_state != ST_WR);
        mem_data_in     = (r_op == c_op_w) ? r_wdata : w_merge_data;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= ST_IDLE;
            r_store  <= 1'b0;
            r_op     <= 3'b000;
            r_addr   <= 32'h0;
            r_wdata  <= 32'h0;
            r_rd     <= 5'd0;
            r_fault  <= 1'b0;
            done     <= 1'b0;
            wb_valid <= 1'b0;
            fault    <= 1'b0;
            wb_data  <= 32'h0;
            wb_rd    <= 5'd0;
        end else begin
            done     <= 1'b0;
            wb_valid <= 1'b0;
            fault    <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_store <= req_store;
                        r_op    <= req_op;
                        r_addr  <= req_addr;
                        r_wdata <= req_wdata;
                        r_rd    <= req_rd;
                        r_fault <= w_fault;
                        if (w_fault)                           r_state <= ST_FIN;
                        else if (req_store && req_op == c_op_w) r_state <= ST_WR;
                        else                                   r_state <= ST_RD;
                    end
                end
                ST_RD: r_state <= ST_CAP;
                ST_CAP: begin
                    if (r_store) begin
                        r_state <= ST_WR;
                    end else begin
                        wb_data  <= w_load_data;
                        wb_rd    <= r_rd;
                        wb_valid <= 1'b1;
                        done     <= 1'b1;
                        r_state  <= ST_IDLE;
                    end
                end
                ST_WR: r_state <= ST_FIN;
                ST_FIN: begin
                    done    <= 1'b1;
                    fault   <= r_fault;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// Testbench for load_store_unit: directed vector table, reset-in-flight and
// back-to-back sequences, and random ops against a byte-level memory model.
module tb_load_store_unit;

    localparam logic [31:0] c_base      = 32'h8002_0000;
    localparam int unsigned c_mem_bytes = 1048576;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_store;
    logic [2:0]  req_op;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [4:0]  req_rd;
    logic [31:0] mem_address;
    logic [31:0] mem_data_in;
    logic [1:0]  mem_access_size;
    logic        mem_rw;
    logic        mem_enable;
    logic [31:0] mem_data_out;
    logic        done;
    logic        wb_valid;
    logic [31:0] wb_data;
    logic [4:0]  wb_rd;
    logic        fault;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    load_store_unit #(.BASE_ADDR(c_base), .MEM_BYTES(c_mem_bytes)) dut (
        .clock(clock), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
        .req_op(req_op), .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
        .mem_address(mem_address), .mem_data_in(mem_data_in),
        .mem_access_size(mem_access_size), .mem_rw(mem_rw), .mem_enable(mem_enable),
        .mem_data_out(mem_data_out), .done(done), .wb_valid(wb_valid),
        .wb_data(wb_data), .wb_rd(wb_rd), .fault(fault)
    );

    // Word memory with registered read; the tests only touch BASE..BASE+0xFF and the top word.
    bit [31:0] mem_words [128];
    int n_rd = 0;
    int n_wr = 0;
    always @(posedge clock) begin
        if (mem_enable) begin
            if (mem_rw) begin
                mem_data_out <= mem_words[mem_address[8:2]];
                n_rd <= n_rd + 1;
            end else begin
                mem_words[mem_address[8:2]] <= mem_data_in;
                n_wr <= n_wr + 1;
            end
        end
    end

    // Reference: byte-addressed, big-endian memory.
    bit [7:0] ref_bytes [bit [31:0]];

    function automatic bit [7:0] ref_get(input bit [31:0] a);
        return ref_bytes.exists(a) ? ref_bytes[a] : 8'h00;
    endfunction

    function automatic void ref_exec(input logic st, input logic [2:0] op, input logic [31:0] a,
                                     input logic [31:0] wd, output logic f, output logic wv,
                                     output logic [31:0] d);
        int n;
        bit sgn;
        longint unsigned la;
        longint unsigned v;
        n = 0; sgn = 0; wv = 0; d = 0;
        case (op)
            3'b000: begin n = 1; sgn = 1; end
            3'b001: begin n = 2; sgn = 1; end
            3'b011: n = 4;
            3'b100: n = 1;
            3'b101: n = 2;
            default: n = 0;
        endcase
        la = longint'(a);
        f = (n == 0);
        if (!f)
            f = ((la % n) != 0) || (st && (op == 3'b100 || op == 3'b101)) ||
                (la < longint'(c_base)) || (la >= longint'(c_base) + c_mem_bytes);
        if (f) return;
        if (st) begin
            for (int i = 0; i < n; i++)
                ref_bytes[a + 32'(i)] = 8'(wd >> (8 * (n - 1 - i)));
        end else begin
            v = 0;
            for (int i = 0; i < n; i++) v = (v << 8) | longint'(ref_get(a + 32'(i)));
            if (sgn && (((v >> (8 * n - 1)) & 1) != 0)) v = v | ~((64'd1 << (8 * n)) - 1);
            d  = v[31:0];
            wv = 1;
        end
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
        end
    endtask

    task automatic run_op(input logic st, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] wd, input logic [4:0] rd,
                          output logic f, output logic wv, output logic [31:0] d,
                          output logic [4:0] r, output int lat, output int rds, output int wrs);
        int rd0, wr0;
        logic got;
        @(negedge clock);
        req_store = st; req_op = op; req_addr = a; req_wdata = wd; req_rd = rd;
        req_valid = 1'b1;
        for (int i = 0; i < 20 && !req_ready; i++) @(negedge clock);
        rd0 = n_rd; wr0 = n_wr;
        got = 0; lat = 0; f = 0; wv = 0; d = 0; r = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clock);
            req_valid = 1'b0;
            if (done) begin
                got = 1; lat = i; f = fault; wv = wb_valid; d = wb_data; r = wb_rd;
                break;
            end
        end
        rds = n_rd - rd0;
        wrs = n_wr - wr0;
        check("done_seen", 32'(got), 32'd1);
    endtask

    task automatic gen_op(output logic st, output logic [2:0] op, output logic [31:0] a,
                          output logic [31:0] wd, output logic [4:0] rd);
        int unsigned k, off, sel;
        k = $urandom_range(0, 11);
        case (k)
            0, 1:       op = 3'b000;
            2, 3:       op = 3'b001;
            4, 5, 6:    op = 3'b011;
            7, 8:       op = 3'b100;
            9:          op = 3'b101;
            10:         op = 3'b110;
            default:    op = 3'b111;
        endcase
        st = ($urandom_range(0, 2) == 0);
        if ($urandom_range(0, 4) == 0)              off = $urandom_range(0, 3);
        else if (op == 3'b011)                      off = 0;
        else if (op == 3'b001 || op == 3'b101)      off = 2 * $urandom_range(0, 1);
        else                                        off = $urandom_range(0, 3);
        sel = $urandom_range(0, 15);
        if (sel == 0)      a = c_base - 32'd4 + off;
        else if (sel == 1) a = c_base + c_mem_bytes + off;
        else               a = c_base + 32'($urandom_range(0, 15)) * 4 + off;
        wd = $urandom;
        rd = 5'($urandom_range(1, 31));
    endtask

    typedef struct {
        logic st; logic [2:0] op; logic [31:0] addr; logic [31:0] wdata; logic [4:0] rd;
        logic ef; logic ewv; logic [31:0] edata; int elat; int erds; int ewrs;
    } vec_t;

    typedef struct { logic f; logic wv; logic [31:0] d; logic [4:0] r; } exp_t;

    vec_t vq[$];
    exp_t eq[$];

    logic        o_f, o_wv, m_f, m_wv;
    logic [31:0] o_d, m_d;
    logic [4:0]  o_r;
    int          o_lat, o_rds, o_wrs;
    logic        g_st;
    logic [2:0]  g_op;
    logic [31:0] g_a, g_wd;
    logic [4:0]  g_rd;
    logic        b_st [8];
    logic [2:0]  b_op [8];
    logic [31:0] b_a  [8];
    logic [31:0] b_wd [8];
    logic [4:0]  b_rd [8];

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion expected $finish");
        $fatal(1);
    end

    initial begin
        int wr0, idx, accepted, dones, extra;
        logic pend, reached;
        exp_t e;

        reset_n = 1'b0; req_valid = 1'b0; req_store = 1'b0; req_op = 3'b000;
        req_addr = 32'h0; req_wdata = 32'h0; req_rd = 5'd0;
        repeat (3) @(negedge clock);
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_mem_enable", 32'(mem_enable), 32'd0);
        check("rst_mem_rw", 32'(mem_rw), 32'd1);
        check("rst_done", 32'(done), 32'd0);
        check("rst_wb_valid", 32'(wb_valid), 32'd0);
        check("rst_fault", 32'(fault), 32'd0);
        check("rst_wb_data", wb_data, 32'h0);
        check("rst_wb_rd", 32'(wb_rd), 32'd0);
        check("rst_access_size", 32'(mem_access_size), 32'd0);
        reset_n = 1'b1;

        //             st    op      addr          wdata         rd  ef  ewv edata        lat rd wr
        vq.push_back('{1'b1, 3'b011, 32'h80020000, 32'hDEADBEEF, 5'd0, 1'b0, 1'b0, 32'h0, -1, 0, 1});
        vq.push_back('{1'b0, 3'b011, 32'h80020000, 32'h0, 5'd5, 1'b0, 1'b1, 32'hDEADBEEF, 3, 1, 0});
        vq.push_back('{1'b1, 3'b011, 32'h80020010, 32'h80F17F01, 5'd0, 1'b0, 1'b0, 32'h0, -1, 0, 1});
        vq.push_back('{1'b0, 3'b000, 32'h80020011, 32'h0, 5'd7, 1'b0, 1'b1, 32'hFFFFFFF1, 3, 1, 0});
        vq.push_back('{1'b0, 3'b100, 32'h80020011, 32'h0, 5'd8, 1'b0, 1'b1, 32'h000000F1, 3, 1, 0});
        vq.push_back('{1'b0, 3'b001, 32'h80020012, 32'h0, 5'd9, 1'b0, 1'b1, 32'h00007F01, 3, 1, 0});
        vq.push_back('{1'b0, 3'b001, 32'h80020010, 32'h0, 5'd10, 1'b0, 1'b1, 32'hFFFF80F1, 3, 1, 0});
        vq.push_back('{1'b0, 3'b101, 32'h80020010, 32'h0, 5'd11, 1'b0, 1'b1, 32'h000080F1, 3, 1, 0});
        vq.push_back('{1'b1, 3'b011, 32'h80020010, 32'h11223344, 5'd0, 1'b0, 1'b0, 32'h0, -1, 0, 1});
        vq.push_back('{1'b1, 3'b000, 32'h80020012, 32'h000000AA, 5'd0, 1'b0, 1'b0, 32'h0, -1, 1, 1});
        vq.push_back('{1'b0, 3'b011, 32'h80020010, 32'h0, 5'd12, 1'b0, 1'b1, 32'h1122AA44, 3, 1, 0});
        vq.push_back('{1'b1, 3'b011, 32'h80020014, 32'hCAFEBEEF, 5'd0, 1'b0, 1'b0, 32'h0, -1, 0, 1});
        vq.push_back('{1'b1, 3'b001, 32'h80020016, 32'h00001234, 5'd0, 1'b0, 1'b0, 32'h0, -1, 1, 1});
        vq.push_back('{1'b0, 3'b011, 32'h80020014, 32'h0, 5'd13, 1'b0, 1'b1, 32'hCAFE1234, 3, 1, 0});
        vq.push_back('{1'b0, 3'b000, 32'h80020017, 32'h0, 5'd14, 1'b0, 1'b1, 32'h00000034, 3, 1, 0});
        vq.push_back('{1'b0, 3'b011, 32'h80020002, 32'h0, 5'd3, 1'b1, 1'b0, 32'h0, 2, 0, 0});
        vq.push_back('{1'b1, 3'b001, 32'h80020001, 32'h0, 5'd0, 1'b1, 1'b0, 32'h0, 2, 0, 0});
        vq.push_back('{1'b0, 3'b000, 32'h8001FFFF, 32'h0, 5'd4, 1'b1, 1'b0, 32'h0, 2, 0, 0});
        vq.push_back('{1'b0, 3'b110, 32'h80020000, 32'h0, 5'd6, 1'b1, 1'b0, 32'h0, 2, 0, 0});
        vq.push_back('{1'b1, 3'b100, 32'h80020000, 32'h0, 5'd0, 1'b1, 1'b0, 32'h0, 2, 0, 0});
        vq.push_back('{1'b0, 3'b011, 32'h80120000, 32'h0, 5'd2, 1'b1, 1'b0, 32'h0, 2, 0, 0});
        vq.push_back('{1'b1, 3'b011, 32'h8011FFFC, 32'h12345678, 5'd0, 1'b0, 1'b0, 32'h0, -1, 0, 1});
        vq.push_back('{1'b0, 3'b011, 32'h8011FFFC, 32'h0, 5'd15, 1'b0, 1'b1, 32'h12345678, 3, 1, 0});

        foreach (vq[i]) begin
            run_op(vq[i].st, vq[i].op, vq[i].addr, vq[i].wdata, vq[i].rd,
                   o_f, o_wv, o_d, o_r, o_lat, o_rds, o_wrs);
            ref_exec(vq[i].st, vq[i].op, vq[i].addr, vq[i].wdata, m_f, m_wv, m_d);
            check($sformatf("vec%0d_fault", i), 32'(o_f), 32'(vq[i].ef));
            check($sformatf("vec%0d_wb_valid", i), 32'(o_wv), 32'(vq[i].ewv));
            if (vq[i].ewv) begin
                check($sformatf("vec%0d_wb_data", i), o_d, vq[i].edata);
                check($sformatf("vec%0d_wb_rd", i), 32'(o_r), 32'(vq[i].rd));
            end
            if (vq[i].elat > 0) check($sformatf("vec%0d_latency", i), o_lat, vq[i].elat);
            check($sformatf("vec%0d_read_strobes", i), o_rds, vq[i].erds);
            check($sformatf("vec%0d_write_strobes", i), o_wrs, vq[i].ewrs);
        end

        for (int n = 0; n < 40; n++) begin
            gen_op(g_st, g_op, g_a, g_wd, g_rd);
            ref_exec(g_st, g_op, g_a, g_wd, m_f, m_wv, m_d);
            run_op(g_st, g_op, g_a, g_wd, g_rd, o_f, o_wv, o_d, o_r, o_lat, o_rds, o_wrs);
            check($sformatf("rnd%0d_fault", n), 32'(o_f), 32'(m_f));
            check($sformatf("rnd%0d_wb_valid", n), 32'(o_wv), 32'(m_wv));
            if (m_wv) begin
                check($sformatf("rnd%0d_wb_data", n), o_d, m_d);
                check($sformatf("rnd%0d_wb_rd", n), 32'(o_r), 32'(g_rd));
                check($sformatf("rnd%0d_latency", n), o_lat, 3);
            end
            if (m_f) check($sformatf("rnd%0d_fault_latency", n), o_lat, 2);
            check($sformatf("rnd%0d_read_strobes", n), o_rds,
                  (!m_f && !(g_st && g_op == 3'b011)) ? 1 : 0);
            check($sformatf("rnd%0d_write_strobes", n), o_wrs, (!m_f && g_st) ? 1 : 0);
        end

        // Reset asserted while an SB sits in its write cycle.
        run_op(1'b1, 3'b011, 32'h80020020, 32'h55667788, 5'd0, o_f, o_wv, o_d, o_r, o_lat, o_rds, o_wrs);
        ref_exec(1'b1, 3'b011, 32'h80020020, 32'h55667788, m_f, m_wv, m_d);
        run_op(1'b0, 3'b011, 32'h80020020, 32'h0, 5'd9, o_f, o_wv, o_d, o_r, o_lat, o_rds, o_wrs);
        ref_exec(1'b0, 3'b011, 32'h80020020, 32'h0, m_f, m_wv, m_d);
        check("rstseq_preload", o_d, m_d);
        @(negedge clock);
        wr0 = n_wr;
        req_store = 1'b1; req_op = 3'b000; req_addr = 32'h80020021; req_wdata = 32'hAA;
        req_rd = 5'd0; req_valid = 1'b1;
        reached = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            req_valid = 1'b0;
            if (mem_enable && !mem_rw) begin reached = 1; break; end
        end
        check("rstseq_reached_wr", 32'(reached), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        check("rstseq_mem_enable", 32'(mem_enable), 32'd0);
        check("rstseq_mem_rw", 32'(mem_rw), 32'd1);
        check("rstseq_req_ready", 32'(req_ready), 32'd1);
        check("rstseq_done", 32'(done), 32'd0);
        check("rstseq_wb_valid", 32'(wb_valid), 32'd0);
        check("rstseq_fault", 32'(fault), 32'd0);
        check("rstseq_wb_data", wb_data, 32'h0);
        check("rstseq_wb_rd", 32'(wb_rd), 32'd0);
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        check("rstseq_ready_after", 32'(req_ready), 32'd1);
        check("rstseq_no_write", n_wr - wr0, 0);
        run_op(1'b0, 3'b011, 32'h80020020, 32'h0, 5'd17, o_f, o_wv, o_d, o_r, o_lat, o_rds, o_wrs);
        ref_exec(1'b0, 3'b011, 32'h80020020, 32'h0, m_f, m_wv, m_d);
        check("rstseq_word_intact", o_d, m_d);

        // req_valid held high across 8 random requests.
        for (int i = 0; i < 8; i++) gen_op(b_st[i], b_op[i], b_a[i], b_wd[i], b_rd[i]);
        b_st[1] = 1'b1; b_op[1] = 3'b011; b_a[1] = c_base + 32'h30;
        b_st[2] = 1'b0; b_op[2] = 3'b011; b_a[2] = c_base + 32'h30;
        @(negedge clock);
        idx = 0; accepted = 0; dones = 0; pend = 0;
        req_store = b_st[0]; req_op = b_op[0]; req_addr = b_a[0];
        req_wdata = b_wd[0]; req_rd = b_rd[0]; req_valid = 1'b1;
        for (int cyc = 0; cyc < 200 && dones < 8; cyc++) begin
            if (pend) begin
                idx++;
                pend = 0;
                if (idx < 8) begin
                    req_store = b_st[idx]; req_op = b_op[idx]; req_addr = b_a[idx];
                    req_wdata = b_wd[idx]; req_rd = b_rd[idx];
                end else begin
                    req_valid = 1'b0;
                end
            end
            if (done) begin
                dones++;
                if (eq.size() == 0) begin
                    check("b2b_unexpected_done", 32'd1, 32'd0);
                end else begin
                    e = eq.pop_front();
                    check($sformatf("b2b%0d_fault", dones), 32'(fault), 32'(e.f));
                    check($sformatf("b2b%0d_wb_valid", dones), 32'(wb_valid), 32'(e.wv));
                    if (e.wv) begin
                        check($sformatf("b2b%0d_wb_data", dones), wb_data, e.d);
                        check($sformatf("b2b%0d_wb_rd", dones), 32'(wb_rd), 32'(e.r));
                    end
                end
            end
            if (req_valid && req_ready) begin
                ref_exec(b_st[idx], b_op[idx], b_a[idx], b_wd[idx], m_f, m_wv, m_d);
                eq.push_back('{m_f, m_wv, m_d, b_rd[idx]});
                accepted++;
                pend = 1;
            end
            @(negedge clock);
        end
        req_valid = 1'b0;
        extra = 0;
        for (int i = 0; i < 6; i++) begin
            if (done) extra++;
            @(negedge clock);
        end
        check("b2b_accepted", accepted, 8);
        check("b2b_dones", dones, 8);
        check("b2b_extra_done", extra, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
